y86_dmem_pipelined: RTL and testbench
=====================================

// Module: y86_dmem_pipelined
// PURPOSE
//  Parametrised data memory for the Y86 pipeline MEMORY stage, one word per access.
//  Clocked stores, 1-cycle registered loads and a valid/ready request handshake.
//  Byte addressing with alignment and range checks, plus a classified error code.
//  Optional post-reset zero-fill. Drives the dmem_error input of the stat/exception logic.
// PARAMETERS
//  DATA_W          64     word width in bits; power of two, >= 8
//  DEPTH           8192   number of words in the array; power of two
//  ADDR_W          64     byte-address width of mem_addr
//  CLEAR_ON_RESET  1      1: zero every word after reset before accepting requests
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   1       request present this cycle
//  req_ready   out  1       block can accept a request (0 while clearing)
//  mem_read    in   1       load request
//  mem_write   in   1       store request
//  mem_addr    in   ADDR_W  byte address
//  M_valA      in   DATA_W  store data
//  mem_data    out  DATA_W  load data, valid when rd_valid=1
//  rd_valid    out  1       1-cycle pulse: mem_data holds a completed load
//  dmem_error  out  1       1-cycle pulse: previous accepted request faulted
//  err_code    out  2       0 none, 1 conflict (rd&wr), 2 out-of-range, 3 misaligned
//  err_sticky  out  1       OR of all faults since reset
// BEHAVIOUR
//  - Reset (async assert, sync release): mem_data=0, rd_valid=0, dmem_error=0,
//    err_code=0, err_sticky=0. req_ready=0 if CLEAR_ON_RESET=1, else 1.
//  - Array contents are not reset. CLEAR_ON_RESET=1: FSM CLEAR->IDLE writes 0 to idx 0..DEPTH-1,
//    one word/cycle, then enters IDLE. req_ready=1 only in IDLE; reset asserted mid-clear restarts at idx 0.
//  - Accept = req_valid & req_ready. Non-accepted cycles: no array access, no output pulse.
//  - BYTES=DATA_W/8. idx = mem_addr >> log2(BYTES). Misaligned: mem_addr % BYTES != 0.
//    Out-of-range: mem_addr >= DEPTH*BYTES, compared on the full ADDR_W with no truncation.
//  - Fault priority: conflict (mem_read&mem_write) > range > align. A faulting request performs
//    no write and no read. Next cycle: dmem_error=1, err_code=code, rd_valid=0. err_sticky sets and holds.
//  - Accepted write, no fault: mem[idx]<=M_valA at that edge. No rd_valid; dmem_error=0.
//  - Accepted read, no fault: next cycle mem_data=mem[idx], rd_valid=1.
//    mem_data holds its value until the next good load.
//  - Read the cycle after a write to the same idx returns the new data. Back-to-back loads
//    give one rd_valid per cycle at full throughput.
//  - Accepted request with neither rd nor wr: no-op, no pulse.
//  - err_code holds its last value. Only dmem_error pulses.
// STRUCTURE
//  - Package y86_mem_pkg: state enum {ST_CLEAR, ST_IDLE}; err_code localparams
//    ERR_NONE/CONFLICT/RANGE/ALIGN; function clog2.
//  - Sub-module dmem_sp_ram (DATA_W, DEPTH): single-port synchronous RAM, one write/read port
//    with read data registered. Top level holds the clear FSM, address checks and error/valid regs.
// TESTING
//  1 CLEAR_ON_RESET=1, DEPTH=16: release rst_n -> req_ready low exactly 16 cycles.
//    Then a read of every addr returns 0.
//  2 Write 0xDEAD_BEEF_0000_0001 to addr 0x40, read 0x40 next cycle -> rd_valid 1 cycle later,
//    mem_data=0xDEAD_BEEF_0000_0001.
//  3 Read addr 0x43 -> dmem_error=1, err_code=3, rd_valid=0. Write to 0x43: verify no word changed.
//  4 DEPTH=8192: read 0x10000 -> err_code=2; also 0xFFFF_FFFF_FFFF_FFF8 -> err_code=2 (no wrap).
//  5 mem_read=mem_write=1, addr 0x43 -> err_code=1 (priority), array unchanged, err_sticky=1
//    persists until rst_n.
//  6 Assert rst_n=0 mid-clear (idx 5): outputs zero immediately. After release the clear restarts,
//    req_ready low DEPTH cycles.

Source files
------------

// File: rtl/y86_mem_pkg.sv
// Shared types and helpers for the Y86 data memory: clear-FSM states,
// error classification codes and a constant-foldable ceil(log2).
package y86_mem_pkg;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CONFLICT = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_ALIGN    = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous RAM: one write-or-read access per cycle, read data
// registered and held until the next read. The array itself is never reset.
module dmem_sp_ram
  import y86_mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8192,
  localparam int IDX_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Only the output register is reset so the load data port starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/y86_dmem_pipelined.sv
// Y86 MEMORY-stage data memory: post-reset clear FSM, request handshake,
// alignment/range/conflict checks and registered load/error results.
module y86_dmem_pipelined
  import y86_mem_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int DEPTH          = 8192,
  parameter int ADDR_W         = 64,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] M_valA,
  output logic [DATA_W-1:0] mem_data,
  output logic              rd_valid,
  output logic              dmem_error,
  output logic [1:0]        err_code,
  output logic              err_sticky
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = clog2(BYTES);
  localparam int IDX_W  = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int SPAN_W = OFF_W + clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

  state_t            state;
  logic [IDX_W-1:0]  clear_idx;
  logic              clearing;
  logic              misaligned;
  logic              out_of_range;
  logic [1:0]        fault_code;
  logic              active;
  logic              faulted;
  logic              good_rd;
  logic              good_wr;
  logic [IDX_W-1:0]  req_idx;
  logic              ram_en;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  // Range test keeps every upper address bit, so huge addresses never alias.
  assign misaligned   = (mem_addr & ALIGN_MASK) != '0;
  assign out_of_range = (mem_addr >> SPAN_W) != '0;
  assign req_idx      = IDX_W'(mem_addr >> OFF_W);

  always_comb begin
    fault_code = ERR_NONE;
    if (mem_read && mem_write) fault_code = ERR_CONFLICT;
    else if (out_of_range)     fault_code = ERR_RANGE;
    else if (misaligned)       fault_code = ERR_ALIGN;
  end

  assign active   = req_valid && req_ready && (mem_read || mem_write);
  assign faulted  = active && (fault_code != ERR_NONE);
  assign good_rd  = active && !faulted && mem_read;
  assign good_wr  = active && !faulted && mem_write;
  assign clearing = (state == ST_CLEAR);

  assign ram_en    = clearing || good_rd || good_wr;
  assign ram_we    = clearing || good_wr;
  assign ram_addr  = clearing ? clear_idx : req_idx;
  assign ram_wdata = clearing ? '0 : M_valA;

  // Clear sweep writes one word per cycle; ready rises with the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clear_idx <= '0;
      req_ready <= (CLEAR_ON_RESET == 0);
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clear_idx == IDX_W'(DEPTH - 1)) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end else begin
            clear_idx <= clear_idx + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid   <= 1'b0;
      dmem_error <= 1'b0;
      err_code   <= ERR_NONE;
      err_sticky <= 1'b0;
    end else begin
      rd_valid   <= good_rd;
      dmem_error <= faulted;
      err_sticky <= err_sticky || faulted;
      if (faulted) err_code <= fault_code;
    end
  end

  dmem_sp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(mem_data)
  );

endmodule

// File: tb/tb_y86_dmem_pipelined.sv
// Bench for y86_dmem_pipelined: a small DEPTH=16 instance with clear-on-reset
// and a full-size DEPTH=8192 instance without it for range checks.
module tb_y86_dmem_pipelined;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [63:0] mem_addr = '0, M_valA = '0;
  logic        req_ready, rd_valid, dmem_error, err_sticky;
  logic [63:0] mem_data;
  logic [1:0]  err_code;

  logic        b_req_valid = 1'b0, b_mem_read = 1'b0, b_mem_write = 1'b0;
  logic [63:0] b_mem_addr = '0, b_M_valA = '0;
  logic        b_req_ready, b_rd_valid, b_dmem_error, b_err_sticky;
  logic [63:0] b_mem_data;
  logic [1:0]  b_err_code;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  y86_dmem_pipelined #(.DATA_W(64), .DEPTH(16), .ADDR_W(64), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .M_valA(M_valA),
    .mem_data(mem_data), .rd_valid(rd_valid), .dmem_error(dmem_error),
    .err_code(err_code), .err_sticky(err_sticky)
  );

  y86_dmem_pipelined #(.DATA_W(64), .DEPTH(8192), .ADDR_W(64), .CLEAR_ON_RESET(0)) dut_big (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr), .M_valA(b_M_valA),
    .mem_data(b_mem_data), .rd_valid(b_rd_valid), .dmem_error(b_dmem_error),
    .err_code(b_err_code), .err_sticky(b_err_sticky)
  );

  typedef struct {
    logic        valid, rd, wr;
    logic [63:0] addr, data;
    logic        exp_rv, exp_err;
    logic [1:0]  exp_code;
    logic [63:0] exp_data;
    logic        exp_sticky;
  } vec_t;

  vec_t vecs[13];

  // Reference model of the small instance: word array plus held outputs.
  logic [63:0] m_mem [16];
  logic [63:0] m_data;
  logic [1:0]  m_code;
  logic        m_sticky, m_rv, m_err;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [63:0] addr, input logic [63:0] data);
    req_valid = v; mem_read = rd; mem_write = wr; mem_addr = addr; M_valA = data;
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic applyBig(input logic rd, input logic wr, input logic [63:0] addr, input logic [63:0] data);
    b_req_valid = 1'b1; b_mem_read = rd; b_mem_write = wr; b_mem_addr = addr; b_M_valA = data;
    @(posedge clk);
    #1;
    b_req_valid = 1'b0; b_mem_read = 1'b0; b_mem_write = 1'b0;
  endtask

  task automatic modelStep(input logic v, input logic rd, input logic wr,
                           input logic [63:0] addr, input logic [63:0] data);
    logic [1:0] code;
    m_rv = 1'b0;
    m_err = 1'b0;
    if (v && (rd || wr)) begin
      if (rd && wr)          code = 2'd1;
      else if (addr >= 128)  code = 2'd2;
      else if (addr % 8 != 0) code = 2'd3;
      else                   code = 2'd0;
      if (code != 2'd0) begin
        m_err = 1'b1; m_code = code; m_sticky = 1'b1;
      end else if (wr) begin
        m_mem[addr / 8] = data;
      end else begin
        m_rv = 1'b1; m_data = m_mem[addr / 8];
      end
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_rv));
    checkOutput({tag, ".dmem_error"}, 64'(dmem_error), 64'(m_err));
    checkOutput({tag, ".err_code"}, 64'(err_code), 64'(m_code));
    checkOutput({tag, ".mem_data"}, mem_data, m_data);
    checkOutput({tag, ".err_sticky"}, 64'(err_sticky), 64'(m_sticky));
    checkOutput({tag, ".req_ready"}, 64'(req_ready), 64'd1);
  endtask

  task automatic countNotReady(output int cnt);
    cnt = 0;
    while (!req_ready && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".mem_data"}, mem_data, 64'd0);
    checkOutput({tag, ".rd_valid"}, 64'(rd_valid), 64'd0);
    checkOutput({tag, ".dmem_error"}, 64'(dmem_error), 64'd0);
    checkOutput({tag, ".err_code"}, 64'(err_code), 64'd0);
    checkOutput({tag, ".err_sticky"}, 64'(err_sticky), 64'd0);
    checkOutput({tag, ".req_ready"}, 64'(req_ready), 64'd0);
  endtask

  task automatic sweepZero(input string tag);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 64'(i * 8), 64'd0);
      checkOutput($sformatf("%s%0d.rd_valid", tag, i), 64'(rd_valid), 64'd1);
      checkOutput($sformatf("%s%0d.mem_data", tag, i), mem_data, 64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    logic v, rd, wr;
    logic [63:0] addr, data;

    vecs[0]  = '{1, 0, 1, 64'h40, 64'hDEAD_BEEF_0000_0001, 0, 0, 2'd0, 64'h0, 0};
    vecs[1]  = '{1, 1, 0, 64'h40, 64'h0, 1, 0, 2'd0, 64'hDEAD_BEEF_0000_0001, 0};
    vecs[2]  = '{1, 1, 0, 64'h43, 64'h0, 0, 1, 2'd3, 64'hDEAD_BEEF_0000_0001, 1};
    vecs[3]  = '{1, 0, 1, 64'h43, 64'h1111, 0, 1, 2'd3, 64'hDEAD_BEEF_0000_0001, 1};
    vecs[4]  = '{1, 1, 0, 64'h40, 64'h0, 1, 0, 2'd3, 64'hDEAD_BEEF_0000_0001, 1};
    vecs[5]  = '{1, 1, 1, 64'h43, 64'h2222, 0, 1, 2'd1, 64'hDEAD_BEEF_0000_0001, 1};
    vecs[6]  = '{1, 1, 0, 64'h80, 64'h0, 0, 1, 2'd2, 64'hDEAD_BEEF_0000_0001, 1};
    vecs[7]  = '{1, 1, 0, 64'h78, 64'h0, 1, 0, 2'd2, 64'h0, 1};
    vecs[8]  = '{0, 1, 0, 64'h40, 64'h0, 0, 0, 2'd2, 64'h0, 1};
    vecs[9]  = '{1, 0, 0, 64'h43, 64'h0, 0, 0, 2'd2, 64'h0, 1};
    vecs[10] = '{1, 0, 1, 64'h48, 64'h0123_4567_89AB_CDEF, 0, 0, 2'd2, 64'h0, 1};
    vecs[11] = '{1, 1, 0, 64'h48, 64'h0, 1, 0, 2'd2, 64'h0123_4567_89AB_CDEF, 1};
    vecs[12] = '{1, 1, 0, 64'h40, 64'h0, 1, 0, 2'd2, 64'hDEAD_BEEF_0000_0001, 1};

    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    checkOutput("big.reset_ready", 64'(b_req_ready), 64'd1);
    rst_n = 1'b1;
    countNotReady(cnt);
    checkOutput("clear_cycles", 64'(cnt), 64'd16);
    sweepZero("clear_read");

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("vec%0d.rd_valid", i), 64'(rd_valid), 64'(vecs[i].exp_rv));
      checkOutput($sformatf("vec%0d.dmem_error", i), 64'(dmem_error), 64'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d.err_code", i), 64'(err_code), 64'(vecs[i].exp_code));
      checkOutput($sformatf("vec%0d.mem_data", i), mem_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d.err_sticky", i), 64'(err_sticky), 64'(vecs[i].exp_sticky));
    end

    for (int i = 0; i < 16; i++) m_mem[i] = 64'd0;
    m_mem[8] = 64'hDEAD_BEEF_0000_0001;
    m_mem[9] = 64'h0123_4567_89AB_CDEF;
    m_data = 64'hDEAD_BEEF_0000_0001;
    m_code = 2'd2;
    m_sticky = 1'b1;

    for (int i = 0; i < 16; i++) begin
      modelStep(1'b1, 1'b1, 1'b0, 64'(i * 8), 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 64'(i * 8), 64'd0);
      checkModel($sformatf("sweep%0d", i));
    end

    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      data = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        6:       addr = 64'($urandom_range(0, 15) * 8 + $urandom_range(1, 7));
        7:       addr = 64'(128 + $urandom_range(0, 255));
        8:       addr = {$urandom, $urandom};
        default: addr = 64'($urandom_range(0, 15) * 8);
      endcase
      modelStep(v, rd, wr, addr, data);
      applyStimulus(v, rd, wr, addr, data);
      checkModel($sformatf("rand%0d", i));
    end

    applyBig(1'b0, 1'b1, 64'hFFF8, 64'hA5A5_5A5A_0F0F_F0F0);
    checkOutput("big.wr_error", 64'(b_dmem_error), 64'd0);
    applyBig(1'b1, 1'b0, 64'hFFF8, 64'd0);
    checkOutput("big.rd_valid", 64'(b_rd_valid), 64'd1);
    checkOutput("big.rd_data", b_mem_data, 64'hA5A5_5A5A_0F0F_F0F0);
    applyBig(1'b1, 1'b0, 64'h1_0000, 64'd0);
    checkOutput("big.range_error", 64'(b_dmem_error), 64'd1);
    checkOutput("big.range_code", 64'(b_err_code), 64'd2);
    checkOutput("big.range_rv", 64'(b_rd_valid), 64'd0);
    applyBig(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0);
    checkOutput("big.wrap_error", 64'(b_dmem_error), 64'd1);
    checkOutput("big.wrap_code", 64'(b_err_code), 64'd2);
    checkOutput("big.wrap_rv", 64'(b_rd_valid), 64'd0);
    checkOutput("big.sticky", 64'(b_err_sticky), 64'd1);
    checkOutput("big.data_hold", b_mem_data, 64'hA5A5_5A5A_0F0F_F0F0);

    applyStimulus(1'b1, 1'b0, 1'b1, 64'h40, 64'h5A5A_1234_5678_9ABC);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h40, 64'd0);
    checkOutput("pre_reset.mem_data", mem_data, 64'h5A5A_1234_5678_9ABC);
    checkOutput("pre_reset.sticky", 64'(err_sticky), 64'd1);

    rst_n = 1'b0;
    #1;
    checkResetOutputs("reset2");
    checkOutput("big.reset2_sticky", 64'(b_err_sticky), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midclear");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    countNotReady(cnt);
    checkOutput("restart_clear_cycles", 64'(cnt), 64'd16);
    sweepZero("reclear_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
